// File: rtl/instruction_decode_control.sv
// Decode-side controller for the program-memory fetch stage.
// Detects jumps, load-use hazards, multi-cycle multiplies and HALT, steers
// the fetch stage (redirect / hold), and issues accepted instructions into
// a registered decode/execute slot.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_BOOT     | first cycle after reset; ins ignored, bubble issued
// ST_RUN      | normal decode of the present ins
// ST_MUL_WAIT | multiply still occupying execute; mcnt counts down to 0
// ST_HALTED   | stopped by HALT; sticky until reset
module instruction_decode_control #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic [15:0] current_address,
  output logic        pc_mux_sel,
  output logic [15:0] jmp_loc,
  output logic        stall,
  output logic        stall_pm,
  output logic        ex_valid,
  output logic [31:0] ex_ins,
  output logic [15:0] ex_pc,
  output logic        halted
);

  // Opcodes not listed here (including 000000) decode as ALU.
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_MUL  = 6'b011000;
  localparam logic [5:0] OP_JMP  = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Cycles the multiply still holds execute after the cycle it issues in.
  localparam logic [3:0] MCNT_LOAD = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_MUL_WAIT,
    ST_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [15:0] pc_q, pc_d;
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_ins_q, ex_ins_d;
  logic [15:0] ex_pc_q, ex_pc_d;
  logic        halted_q, halted_d;

  logic        stall_c;
  logic        issue;

  // Present instruction fields.
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        is_lw, is_mul, is_jmp, is_halt;
  logic        reads_rs, reads_rt;

  assign op       = ins[31:26];
  assign rs       = ins[20:16];
  assign rt       = ins[15:11];
  assign is_lw    = (op == OP_LW);
  assign is_mul   = (op == OP_MUL);
  assign is_jmp   = (op == OP_JMP);
  assign is_halt  = (op == OP_HALT);
  assign reads_rs = !is_jmp && !is_halt;
  assign reads_rt = reads_rs && !is_lw;

  // Load in execute whose destination is not yet available to decode.
  // rd = 0 is excluded here, so register 0 can never match below.
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        load_use;

  assign ex_rd      = ex_ins_q[25:21];
  assign ex_is_load = ex_valid_q && (ex_ins_q[31:26] == OP_LW) && (ex_rd != 5'd0);
  assign load_use   = ex_is_load &&
                      ((reads_rs && (rs == ex_rd)) || (reads_rt && (rt == ex_rd)));

  // Next-state decision and combinational fetch controls.
  always_comb begin
    state_d    = state_q;
    mcnt_d     = mcnt_q;
    halted_d   = halted_q;
    stall_c    = 1'b0;
    pc_mux_sel = 1'b0;
    jmp_loc    = 16'h0000;
    issue      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (is_halt) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (load_use) begin
          stall_c = 1'b1;
        end else if (is_jmp) begin
          // Redirect is seen by fetch this cycle, so nothing needs squashing.
          pc_mux_sel = 1'b1;
          jmp_loc    = ins[15:0];
        end else if (is_mul) begin
          issue = 1'b1;
          if (MUL_LAT > 1) begin
            mcnt_d  = MCNT_LOAD;
            state_d = ST_MUL_WAIT;
          end
        end else begin
          issue = 1'b1;
        end
      end

      ST_MUL_WAIT: begin
        stall_c = 1'b1;
        if (mcnt_q <= 4'd1) begin
          mcnt_d  = 4'd0;
          state_d = ST_RUN;
        end else begin
          mcnt_d = mcnt_q - 4'd1;
        end
      end

      ST_HALTED: begin
        stall_c  = 1'b1;
        halted_d = 1'b1;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Issue slot contents and instruction-address tracking.
  always_comb begin
    ex_valid_d = issue;
    ex_ins_d   = issue ? ins : 32'h0000_0000;
    ex_pc_d    = issue ? pc_q : 16'h0000;
    pc_d       = stall_c ? pc_q : current_address;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      mcnt_q     <= 4'd0;
      pc_q       <= 16'h0000;
      ex_valid_q <= 1'b0;
      ex_ins_q   <= 32'h0000_0000;
      ex_pc_q    <= 16'h0000;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcnt_q     <= mcnt_d;
      pc_q       <= pc_d;
      ex_valid_q <= ex_valid_d;
      ex_ins_q   <= ex_ins_d;
      ex_pc_q    <= ex_pc_d;
      halted_q   <= halted_d;
    end
  end

  assign stall    = stall_c;
  assign stall_pm = stall_c;
  assign ex_valid = ex_valid_q;
  assign ex_ins   = ex_ins_q;
  assign ex_pc    = ex_pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instruction_decode_control.sv
// Directed bench for instruction_decode_control. Each vector is one clock
// cycle of fetch-stage inputs plus hand-computed expectations: the
// combinational controls for that cycle and the ex_*/halted contents after
// the closing edge. A second instance with MUL_LAT=1 shares the inputs and
// is checked only around the multiply sequence.
module tb_instruction_decode_control;

  logic        clk;
  logic        reset;
  logic [31:0] ins;
  logic [15:0] current_address;

  logic        pc_mux_sel, stall, stall_pm, ex_valid, halted;
  logic [15:0] jmp_loc, ex_pc;
  logic [31:0] ex_ins;

  logic        pc_mux_sel1, stall1, stall_pm1, ex_valid1, halted1;
  logic [15:0] jmp_loc1, ex_pc1;
  logic [31:0] ex_ins1;

  instruction_decode_control #(.MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
    .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .stall(stall), .stall_pm(stall_pm),
    .ex_valid(ex_valid), .ex_ins(ex_ins), .ex_pc(ex_pc), .halted(halted)
  );

  instruction_decode_control #(.MUL_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
    .pc_mux_sel(pc_mux_sel1), .jmp_loc(jmp_loc1), .stall(stall1), .stall_pm(stall_pm1),
    .ex_valid(ex_valid1), .ex_ins(ex_ins1), .ex_pc(ex_pc1), .halted(halted1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic [15:0] addr;
    logic        sel;
    logic [15:0] jl;
    logic        st;
    logic        v;
    logic [31:0] ei;
    logic [15:0] ep;
    logic        h;
    logic        chk1;
    logic        st1;
    logic        v1;
  } vec_t;

  vec_t vecs[$];
  vec_t comb_q[$];
  vec_t reg_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] alu(input logic [4:0] rs_f, input logic [4:0] rt_f);
    return {6'b000000, 5'd10, rs_f, rt_f, 11'd0};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd_f, input logic [4:0] rs_f, input logic [4:0] rt_f);
    return {6'b100011, rd_f, rs_f, rt_f, 11'd0};
  endfunction
  function automatic logic [31:0] mul(input logic [4:0] rs_f, input logic [4:0] rt_f);
    return {6'b011000, 5'd11, rs_f, rt_f, 11'd0};
  endfunction
  function automatic logic [31:0] jmp(input logic [15:0] t);
    return {6'b000010, 10'd0, t};
  endfunction
  function automatic logic [31:0] hlt();
    return {6'b111111, 26'd0};
  endfunction
  function automatic logic [31:0] oth(input logic [4:0] rs_f, input logic [4:0] rt_f);
    return {6'b000100, 5'd12, rs_f, rt_f, 11'd0};
  endfunction

  task automatic add(input logic rst, input logic [31:0] i, input logic [15:0] a,
                     input logic sel, input logic [15:0] jl, input logic st,
                     input logic v, input logic [31:0] ei, input logic [15:0] ep,
                     input logic h, input logic chk1 = 1'b0, input logic st1 = 1'b0,
                     input logic v1 = 1'b0);
    vec_t x;
    x.rst = rst; x.ins = i; x.addr = a; x.sel = sel; x.jl = jl; x.st = st;
    x.v = v; x.ei = ei; x.ep = ep; x.h = h; x.chk1 = chk1; x.st1 = st1; x.v1 = v1;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Comb monitor: fetch controls sampled mid-cycle.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        check("pc_mux_sel", {31'd0, pc_mux_sel}, {31'd0, e.sel});
        check("jmp_loc", {16'd0, jmp_loc}, {16'd0, e.jl});
        check("stall", {31'd0, stall}, {31'd0, e.st});
        check("stall_pm", {31'd0, stall_pm}, {31'd0, e.st});
        if (e.chk1) check("stall_lat1", {31'd0, stall1}, {31'd0, e.st1});
      end
    end
  end

  // Register monitor: issue slot sampled just after the closing edge.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        check("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        check("ex_ins", ex_ins, e.ei);
        check("ex_pc", {16'd0, ex_pc}, {16'd0, e.ep});
        check("halted", {31'd0, halted}, {31'd0, e.h});
        if (e.chk1) check("ex_valid_lat1", {31'd0, ex_valid1}, {31'd0, e.v1});
      end
    end
  end

  initial begin
    // Reset: prelude edge plus two reset vectors gives three reset cycles.
    add(1, alu(1,2),   16'h0000, 0, 16'h0000, 0, 0, 32'd0, 16'h0000, 0);
    add(1, alu(1,2),   16'h0000, 0, 16'h0000, 0, 0, 32'd0, 16'h0000, 0);
    // BOOT bubble, then first ALU at address 0.
    add(0, alu(1,2),   16'h0000, 0, 16'h0000, 0, 0, 32'd0, 16'h0000, 0);
    add(0, alu(1,2),   16'h0001, 0, 16'h0000, 0, 1, alu(1,2), 16'h0000, 0);
    // LW r5 then ALU reading r5: one stall, one bubble.
    add(0, lw(5,1,0),  16'h0002, 0, 16'h0000, 0, 1, lw(5,1,0), 16'h0001, 0);
    add(0, alu(5,3),   16'h0003, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, alu(5,3),   16'h0003, 0, 16'h0000, 0, 1, alu(5,3), 16'h0002, 0);
    // LW r0 then ALU reading r0: no stall.
    add(0, lw(0,1,0),  16'h0004, 0, 16'h0000, 0, 1, lw(0,1,0), 16'h0003, 0);
    add(0, alu(0,0),   16'h0005, 0, 16'h0000, 0, 1, alu(0,0), 16'h0004, 0);
    // LW does not read its rt field; ALU hazard through rt.
    add(0, lw(6,2,0),  16'h0006, 0, 16'h0000, 0, 1, lw(6,2,0), 16'h0005, 0);
    add(0, lw(7,3,6),  16'h0007, 0, 16'h0000, 0, 1, lw(7,3,6), 16'h0006, 0);
    add(0, alu(2,7),   16'h0008, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, alu(2,7),   16'h0008, 0, 16'h0000, 0, 1, alu(2,7), 16'h0007, 0);
    // LW then JMP redirects at once; JMP at 0x0010 to 0x0040.
    add(0, lw(9,1,0),  16'h0009, 0, 16'h0000, 0, 1, lw(9,1,0), 16'h0008, 0);
    add(0, jmp(16'h0010), 16'h0010, 1, 16'h0010, 0, 0, 32'd0, 16'h0000, 0);
    add(0, jmp(16'h0040), 16'h0040, 1, 16'h0040, 0, 0, 32'd0, 16'h0000, 0);
    add(0, alu(3,4),   16'h0041, 0, 16'h0000, 0, 1, alu(3,4), 16'h0040, 0);
    // MUL then ALU: two stall cycles at MUL_LAT=3, none at MUL_LAT=1.
    add(0, mul(1,2),   16'h0042, 0, 16'h0000, 0, 1, mul(1,2), 16'h0041, 0, 1, 0, 1);
    add(0, alu(1,3),   16'h0043, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0, 1, 0, 1);
    add(0, alu(1,3),   16'h0043, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0, 1, 0, 1);
    add(0, alu(1,3),   16'h0043, 0, 16'h0000, 0, 1, alu(1,3), 16'h0042, 0, 1, 0, 1);
    // Back-to-back MULs.
    add(0, mul(4,5),   16'h0044, 0, 16'h0000, 0, 1, mul(4,5), 16'h0043, 0);
    add(0, mul(6,7),   16'h0045, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, mul(6,7),   16'h0045, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, mul(6,7),   16'h0045, 0, 16'h0000, 0, 1, mul(6,7), 16'h0044, 0);
    add(0, alu(8,9),   16'h0046, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    // Reset while mcnt=1, then BOOT bubble and normal issue.
    add(1, alu(8,9),   16'h0046, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, alu(8,9),   16'h0046, 0, 16'h0000, 0, 0, 32'd0, 16'h0000, 0);
    add(0, alu(1,1),   16'h0047, 0, 16'h0000, 0, 1, alu(1,1), 16'h0046, 0);
    // HALT, sticky with arbitrary ins, then single-cycle reset.
    add(0, hlt(),      16'h0048, 0, 16'h0000, 0, 0, 32'd0, 16'h0000, 1);
    add(0, jmp(16'h1234), 16'h0048, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 1);
    add(0, lw(5,5,0),  16'h0048, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 1);
    add(0, mul(2,2),   16'h0048, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 1);
    add(1, alu(2,3),   16'h0000, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, alu(2,3),   16'h0000, 0, 16'h0000, 0, 0, 32'd0, 16'h0000, 0);
    add(0, alu(2,3),   16'h0001, 0, 16'h0000, 0, 1, alu(2,3), 16'h0000, 0);
    // JMP held during MUL_WAIT is not acted on until RUN.
    add(0, mul(1,1),   16'h0002, 0, 16'h0000, 0, 1, mul(1,1), 16'h0001, 0);
    add(0, jmp(16'h0080), 16'h0003, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, jmp(16'h0080), 16'h0003, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, jmp(16'h0080), 16'h0080, 1, 16'h0080, 0, 0, 32'd0, 16'h0000, 0);
    add(0, alu(0,0),   16'h0081, 0, 16'h0000, 0, 1, alu(0,0), 16'h0080, 0);
    // Unlisted opcode decodes as ALU and reads rt.
    add(0, lw(3,0,0),  16'h0082, 0, 16'h0000, 0, 1, lw(3,0,0), 16'h0081, 0);
    add(0, oth(0,3),   16'h0083, 0, 16'h0000, 1, 0, 32'd0, 16'h0000, 0);
    add(0, oth(0,3),   16'h0083, 0, 16'h0000, 0, 1, oth(0,3), 16'h0082, 0);

    reset = 1'b1;
    ins = 32'd0;
    current_address = 16'h0000;
    @(posedge clk);
    #2;
    foreach (vecs[k]) begin
      reset           = vecs[k].rst;
      ins             = vecs[k].ins;
      current_address = vecs[k].addr;
      comb_q.push_back(vecs[k]);
      reg_q.push_back(vecs[k]);
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
    ins = alu(0,0);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", comb_q.size() + reg_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
